// File: rtl/io_input_conditioner_pkg.sv
// Shared constants for the board input conditioner and the data_memory IO read map.
package io_input_conditioner_pkg;

    localparam int unsigned N_SW_DEFAULT  = 10;
    localparam int unsigned N_KEY_DEFAULT = 4;

    // Bit positions of each field inside io_input_bus, as seen by data_memory.
    localparam int unsigned SW_LSB      = 0;
    localparam int unsigned KEY_LSB     = 10;
    localparam int unsigned IO_IN_WIDTH = 14;

    typedef logic [IO_IN_WIDTH-1:0] io_in_bus_t;

    // Width of a debounce counter able to hold 0..stable.
    function automatic int unsigned cnt_width(int unsigned stable);
        return $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/io_debounce_bit.sv
// One input bit: 2-flop synchroniser followed by a tick-sampled debouncer.
module io_debounce_bit
    import io_input_conditioner_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic raw_in,
    output logic level_out
);

    localparam int unsigned     CW       = cnt_width(STABLE_SAMPLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_SAMPLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Synchronise the raw pin, then on each tick count consecutive mismatches.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            level_out <= 1'b0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            if (tick) begin
                if (sync2 == level_out) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level_out <= sync2;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions slide switches and push-buttons into stable, active-high levels
// for the data_memory IO read path, plus one-cycle key press pulses.
// Optional macro KEY_LATCH_EN: key field of io_input_bus shows sticky press
// latches (cleared by key_clear) instead of the debounced key levels.
module io_input_conditioner
    import io_input_conditioner_pkg::*;
#(
    parameter int unsigned N_SW           = N_SW_DEFAULT,
    parameter int unsigned N_KEY          = N_KEY_DEFAULT,
    parameter int unsigned PRESCALE       = 50000,
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_SW-1:0]       sw_in,
    input  logic [N_KEY-1:0]      key_in,
    input  logic [N_KEY-1:0]      key_clear,
    output logic [N_SW+N_KEY-1:0] io_input_bus,
    output logic [N_KEY-1:0]      key_event
);

    localparam int unsigned   N_IN     = N_SW + N_KEY;
    localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [N_IN-1:0]  raw;
    logic [N_IN-1:0]  level;
    logic [N_KEY-1:0] key_level_d;

    // Keys are normalised to active-high before the synchroniser; switches pass through.
    assign raw  = {key_in ^ {N_KEY{KEY_ACTIVE_LOW}}, sw_in};
    assign tick = (pre_cnt == PRE_LAST);

    // Free-running sample prescaler, 0..PRESCALE-1.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_bit
        io_debounce_bit #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_debounce (
            .clock    (clock),
            .reset    (reset),
            .tick     (tick),
            .raw_in   (raw[i]),
            .level_out(level[i])
        );
    end

    // Rising-edge detect on debounced key levels; pulse lands the cycle after the level rises.
    always_ff @(posedge clock) begin
        if (!reset) begin
            key_level_d <= '0;
            key_event   <= '0;
        end else begin
            key_level_d <= level[N_IN-1:N_SW];
            key_event   <= level[N_IN-1:N_SW] & ~key_level_d;
        end
    end

`ifdef KEY_LATCH_EN
    logic [N_KEY-1:0] key_latch;
    logic [N_SW-1:0]  sw_bus;

    // Sticky press latches (set beats clear) and registered switch levels.
    always_ff @(posedge clock) begin
        if (!reset) begin
            key_latch <= '0;
            sw_bus    <= '0;
        end else begin
            key_latch <= (key_latch & ~key_clear) | key_event;
            sw_bus    <= level[N_SW-1:0];
        end
    end

    assign io_input_bus = {key_latch, sw_bus};
`else
    logic unused_key_clear;
    assign unused_key_clear = ^key_clear;

    // Registered copy of all debounced levels.
    always_ff @(posedge clock) begin
        if (!reset) begin
            io_input_bus <= '0;
        end else begin
            io_input_bus <= level;
        end
    end
`endif

endmodule
